// File: rtl/serv_csr_pkg.sv
// Shared encodings for the SERV machine-mode CSR/interrupt slice.
// Bit positions are architectural CSR bit indices; IRQ_* index the packed {mei, mti, msi} vectors.
package serv_csr_pkg;

    typedef enum logic [1:0] {
        CSR_SOURCE_CSR = 2'b00,
        CSR_SOURCE_EXT = 2'b01,
        CSR_SOURCE_SET = 2'b10,
        CSR_SOURCE_CLR = 2'b11
    } csr_source_e;

    localparam int unsigned MIE_BIT    = 3;
    localparam int unsigned MPIE_BIT   = 7;
    localparam int unsigned MSI        = 3;
    localparam int unsigned MTI        = 7;
    localparam int unsigned MEI        = 11;
    localparam int unsigned MCAUSE_INT = 31;

    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    localparam int unsigned IRQ_MSI = 0;
    localparam int unsigned IRQ_MTI = 1;
    localparam int unsigned IRQ_MEI = 2;

endpackage

// File: rtl/serv_irq_sync.sv
// Interrupt line synchroniser, pending mask, fixed-priority encoder and
// rising-edge detector producing the registered new-interrupt request.
module serv_irq_sync
    import serv_csr_pkg::*;
#(
    parameter              RESET_STRATEGY = "MINI",
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_init,
    input  logic       i_cnt_done,
    input  logic [2:0] i_lines,
    input  logic [2:0] i_mie,
    input  logic       i_gie,
    output logic [2:0] o_mip,
    output logic       o_new_irq,
    output logic [3:0] o_irq_code
);

    localparam logic RST_EN = (RESET_STRATEGY != "NONE");

    logic [2:0] pend;
    logic       pend_any_q, pend_any_d;
    logic       new_irq_q, new_irq_d;
    logic [3:0] irq_code_q, irq_code_d;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign o_mip = i_lines;
        end else begin : g_sync
            logic [2:0] sync_q [SYNC_STAGES];
            logic [2:0] sync_d [SYNC_STAGES];

            always_comb begin
                sync_d[0] = i_lines;
                for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                    sync_d[s] = sync_q[s-1];
                end
            end

            always_ff @(posedge i_clk) begin
                if (RST_EN && i_rst) begin
                    for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                        sync_q[s] <= '0;
                    end
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign o_mip = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign pend = o_mip & i_mie & {3{i_gie}};

    // irq_code only matters while something is pending, so it holds otherwise
    always_comb begin
        pend_any_d = pend_any_q;
        new_irq_d  = new_irq_q;
        irq_code_d = irq_code_q;
        if (!i_init && i_cnt_done) begin
            pend_any_d = |pend;
            new_irq_d  = (|pend) & ~pend_any_q;
            if (pend[IRQ_MEI]) begin
                irq_code_d = CAUSE_MEI;
            end else if (pend[IRQ_MSI]) begin
                irq_code_d = CAUSE_MSI;
            end else if (pend[IRQ_MTI]) begin
                irq_code_d = CAUSE_MTI;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        irq_code_q <= irq_code_d;
        if (RST_EN && i_rst) begin
            pend_any_q <= 1'b0;
            new_irq_q  <= 1'b0;
        end else begin
            pend_any_q <= pend_any_d;
            new_irq_q  <= new_irq_d;
        end
    end

    assign o_new_irq  = new_irq_q;
    assign o_irq_code = irq_code_q;

endmodule

// File: rtl/serv_csr_irq.sv
// Bit-serial (W bits/cycle) machine-mode CSR slice: mstatus.MIE/MPIE, mie, mip, mcause,
// merged with register-file-backed CSR read data.
module serv_csr_irq
    import serv_csr_pkg::*;
#(
    parameter              RESET_STRATEGY = "MINI",
    parameter int unsigned W              = 1,
    parameter int unsigned B              = W - 1,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_init,
    input  logic       i_en,
    input  logic [4:0] i_cnt,
    input  logic       i_cnt_done,
    input  logic       i_trap,
    input  logic       i_mret,
    input  logic       i_mstatus_en,
    input  logic       i_mie_en,
    input  logic       i_mip_en,
    input  logic       i_mcause_en,
    input  logic [1:0] i_csr_source,
    input  logic       i_csr_d_sel,
    input  logic [3:0] i_exc_code,
    input  logic       i_msip,
    input  logic       i_mtip,
    input  logic       i_meip,
    input  logic [B:0] i_rf_csr_out,
    input  logic [B:0] i_csr_imm,
    input  logic [B:0] i_rs1,
    output logic [B:0] o_csr_in,
    output logic [B:0] o_q,
    output logic       o_new_irq
);

    localparam logic RST_EN = (RESET_STRATEGY != "NONE");

    logic [2:0] mie_q, mie_d;
    logic       mstatus_mie_q, mstatus_mie_d;
    logic       mpie_q, mpie_d;
    logic [3:0] mcause_code_q, mcause_code_d;
    logic       mcause_int_q, mcause_int_d;
    logic [2:0] mip;
    logic [3:0] irq_code;
    logic [B:0] d;
    logic [B:0] csr_out;

    serv_irq_sync #(
        .RESET_STRATEGY (RESET_STRATEGY),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_irq (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_init     (i_init),
        .i_cnt_done (i_cnt_done),
        .i_lines    ({i_meip, i_mtip, i_msip}),
        .i_mie      (mie_q),
        .i_gie      (mstatus_mie_q),
        .o_mip      (mip),
        .o_new_irq  (o_new_irq),
        .o_irq_code (irq_code)
    );

    always_comb begin : csr_read
        logic [4:0] idx;
        logic       st_bit, ie_bit, ip_bit, ca_bit;
        idx     = '0;
        st_bit  = 1'b0;
        ie_bit  = 1'b0;
        ip_bit  = 1'b0;
        ca_bit  = 1'b0;
        d       = i_csr_d_sel ? i_csr_imm : i_rs1;
        csr_out = '0;
        for (int unsigned k = 0; k < W; k++) begin
            idx    = i_cnt + 5'(k);
            ie_bit = 1'b0;
            ip_bit = 1'b0;
            case (idx)
                5'(MSI): begin ie_bit = mie_q[IRQ_MSI]; ip_bit = mip[IRQ_MSI]; end
                5'(MTI): begin ie_bit = mie_q[IRQ_MTI]; ip_bit = mip[IRQ_MTI]; end
                5'(MEI): begin ie_bit = mie_q[IRQ_MEI]; ip_bit = mip[IRQ_MEI]; end
                default: ;
            endcase
            st_bit = (idx == 5'(MIE_BIT))  ? mstatus_mie_q :
                     (idx == 5'(MPIE_BIT)) ? mpie_q : 1'b0;
            ca_bit = (idx < 5'd4)              ? mcause_code_q[idx[1:0]] :
                     (idx == 5'(MCAUSE_INT))   ? mcause_int_q : 1'b0;
            csr_out[k] = i_rf_csr_out[k] |
                         (i_en & ((i_mstatus_en & st_bit) | (i_mie_en & ie_bit) |
                                  (i_mip_en & ip_bit) | (i_mcause_en & ca_bit)));
        end
        o_q      = csr_out;
        o_csr_in = csr_out;
        case (csr_source_e'(i_csr_source))
            CSR_SOURCE_CSR: o_csr_in = csr_out;
            CSR_SOURCE_EXT: o_csr_in = d;
            CSR_SOURCE_SET: o_csr_in = csr_out | d;
            CSR_SOURCE_CLR: o_csr_in = csr_out & ~d;
            default: ;
        endcase
    end

    always_comb begin : csr_write
        logic [4:0] widx;
        widx          = '0;
        mie_d         = mie_q;
        mstatus_mie_d = mstatus_mie_q;
        mpie_d        = mpie_q;
        mcause_code_d = mcause_code_q;
        mcause_int_d  = mcause_int_q;
        for (int unsigned k = 0; k < W; k++) begin
            widx = i_cnt + 5'(k);
            if (i_en && i_mie_en) begin
                case (widx)
                    5'(MSI): mie_d[IRQ_MSI] = o_csr_in[k];
                    5'(MTI): mie_d[IRQ_MTI] = o_csr_in[k];
                    5'(MEI): mie_d[IRQ_MEI] = o_csr_in[k];
                    default: ;
                endcase
            end
            if (i_en && i_mstatus_en) begin
                if (widx == 5'(MIE_BIT))  mstatus_mie_d = o_csr_in[k];
                if (widx == 5'(MPIE_BIT)) mpie_d        = o_csr_in[k];
            end
            if (i_en && i_mcause_en) begin
                if (widx < 5'd4)              mcause_code_d[widx[1:0]] = o_csr_in[k];
                if (widx == 5'(MCAUSE_INT))   mcause_int_d             = o_csr_in[k];
            end
        end
        // trap is applied last so it overrides both mret and same-cycle CSR writes
        if (i_mret && i_cnt_done) begin
            mstatus_mie_d = mpie_q;
            mpie_d        = 1'b1;
        end
        if (i_trap && i_cnt_done) begin
            mpie_d        = mstatus_mie_q;
            mstatus_mie_d = 1'b0;
            mcause_int_d  = o_new_irq;
            mcause_code_d = o_new_irq ? irq_code : i_exc_code;
        end
    end

    always_ff @(posedge i_clk) begin
        mcause_code_q <= mcause_code_d;
        mcause_int_q  <= mcause_int_d;
        if (RST_EN && i_rst) begin
            mie_q         <= '0;
            mstatus_mie_q <= 1'b0;
            mpie_q        <= 1'b0;
        end else begin
            mie_q         <= mie_d;
            mstatus_mie_q <= mstatus_mie_d;
            mpie_q        <= mpie_d;
        end
    end

endmodule

// File: tb/tb_serv_csr_irq.sv
// Directed bench for serv_csr_irq: a W=4 instance carries most scenarios,
// a W=1 instance checks the fully serial read/write path.
module tb_serv_csr_irq;

    localparam logic [3:0] SEL_NONE = 4'b0000;
    localparam logic [3:0] SEL_ST   = 4'b1000;
    localparam logic [3:0] SEL_IE   = 4'b0100;
    localparam logic [3:0] SEL_IP   = 4'b0010;
    localparam logic [3:0] SEL_CA   = 4'b0001;
    localparam logic [1:0] S_CSR = 2'b00, S_EXT = 2'b01, S_SET = 2'b10, S_CLR = 2'b11;

    logic       clk = 1'b0;
    logic       rst, init, en, cnt_done, trap, mret;
    logic       mstatus_en, mie_en, mip_en, mcause_en, csr_d_sel;
    logic [4:0] cnt;
    logic [1:0] src;
    logic [3:0] exc;
    logic       msip = 1'b0, mtip = 1'b0, meip = 1'b0;
    logic [3:0] rf_w4, imm_w4, rs1_w4, csr_in_w4, q_w4;
    logic       irq_w4;
    logic       rf_w1, imm_w1, rs1_w1, csr_in_w1, q_w1;
    logic       irq_w1;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    serv_csr_irq #(.RESET_STRATEGY("MINI"), .W(4), .SYNC_STAGES(2)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_init(init), .i_en(en), .i_cnt(cnt), .i_cnt_done(cnt_done),
        .i_trap(trap), .i_mret(mret), .i_mstatus_en(mstatus_en), .i_mie_en(mie_en),
        .i_mip_en(mip_en), .i_mcause_en(mcause_en), .i_csr_source(src), .i_csr_d_sel(csr_d_sel),
        .i_exc_code(exc), .i_msip(msip), .i_mtip(mtip), .i_meip(meip),
        .i_rf_csr_out(rf_w4), .i_csr_imm(imm_w4), .i_rs1(rs1_w4),
        .o_csr_in(csr_in_w4), .o_q(q_w4), .o_new_irq(irq_w4)
    );

    serv_csr_irq #(.RESET_STRATEGY("MINI"), .W(1), .SYNC_STAGES(2)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_init(init), .i_en(en), .i_cnt(cnt), .i_cnt_done(cnt_done),
        .i_trap(trap), .i_mret(mret), .i_mstatus_en(mstatus_en), .i_mie_en(mie_en),
        .i_mip_en(mip_en), .i_mcause_en(mcause_en), .i_csr_source(src), .i_csr_d_sel(csr_d_sel),
        .i_exc_code(exc), .i_msip(msip), .i_mtip(mtip), .i_meip(meip),
        .i_rf_csr_out(rf_w1), .i_csr_imm(imm_w1), .i_rs1(rs1_w1),
        .o_csr_in(csr_in_w1), .o_q(q_w1), .o_new_irq(irq_w1)
    );

    task automatic quiet();
        en = 1'b0; cnt_done = 1'b0; trap = 1'b0; mret = 1'b0; init = 1'b0; cnt = '0;
        {mstatus_en, mie_en, mip_en, mcause_en} = SEL_NONE;
        src = S_CSR; csr_d_sel = 1'b0;
        rf_w4 = '0; imm_w4 = '0; rs1_w4 = '0; rf_w1 = 1'b0; imm_w1 = 1'b0; rs1_w1 = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        quiet();
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic tick(input int n, input logic in_init);
        quiet();
        cnt_done = 1'b1; init = in_init;
        repeat (n) begin @(posedge clk); #1; end
        quiet();
    endtask

    task automatic trap_cycle(input logic [3:0] code, input logic with_mret);
        quiet();
        trap = 1'b1; mret = with_mret; cnt_done = 1'b1; exc = code;
        @(posedge clk); #1;
        quiet();
    endtask

    task automatic mret_cycle();
        quiet();
        mret = 1'b1; cnt_done = 1'b1;
        @(posedge clk); #1;
        quiet();
    endtask

    // one full 32-bit word through the W=4 instance; the unselected operand carries ~dat
    task automatic word4(input logic [3:0] sel, input logic [1:0] s, input logic dsel,
                         input logic [31:0] dat, input logic [31:0] rf, input logic trap_last,
                         output logic [31:0] q, output logic [31:0] cin);
        quiet();
        {mstatus_en, mie_en, mip_en, mcause_en} = sel;
        src = s; csr_d_sel = dsel; en = 1'b1;
        for (int g = 0; g < 8; g++) begin
            cnt      = 5'(g * 4);
            cnt_done = (g == 7);
            trap     = trap_last & (g == 7);
            rs1_w4   = dsel ? ~dat[g*4 +: 4] : dat[g*4 +: 4];
            imm_w4   = dsel ? dat[g*4 +: 4] : ~dat[g*4 +: 4];
            rf_w4    = rf[g*4 +: 4];
            @(negedge clk);
            q[g*4 +: 4]   = q_w4;
            cin[g*4 +: 4] = csr_in_w4;
            @(posedge clk); #1;
        end
        quiet();
    endtask

    task automatic word1(input logic [3:0] sel, input logic [1:0] s, input logic [31:0] dat,
                         output logic [31:0] q);
        quiet();
        {mstatus_en, mie_en, mip_en, mcause_en} = sel;
        src = s; en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            cnt      = 5'(i);
            cnt_done = (i == 31);
            rs1_w1   = dat[i];
            imm_w1   = ~dat[i];
            @(negedge clk);
            q[i] = q_w1;
            @(posedge clk); #1;
        end
        quiet();
    endtask

    task automatic rd4(input logic [3:0] sel, output logic [31:0] q);
        logic [31:0] cin;
        word4(sel, S_CSR, 1'b0, 32'h0, 32'h0, 1'b0, q, cin);
    endtask

    task automatic wr4(input logic [3:0] sel, input logic [1:0] s, input logic [31:0] dat);
        logic [31:0] q, cin;
        word4(sel, s, 1'b0, dat, 32'h0, 1'b0, q, cin);
    endtask

    task automatic test_reset();
        logic [31:0] q;
        checks++; if (irq_w4 !== 1'b0) begin errors++; $display("FAIL rst_irq_w4 got %b exp 0", irq_w4); end
        checks++; if (irq_w1 !== 1'b0) begin errors++; $display("FAIL rst_irq_w1 got %b exp 0", irq_w1); end
        rd4(SEL_IE, q);
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL rst_mie got %h exp 00000000", q); end
        rd4(SEL_ST, q);
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL rst_mstatus got %h exp 00000000", q); end
        rd4(SEL_IP, q);
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL rst_mip got %h exp 00000000", q); end
    endtask

    task automatic test_rw_w1();
        logic [31:0] q;
        word1(SEL_IE, S_EXT, 32'h0000_0888, q);
        word1(SEL_ST, S_EXT, 32'h0000_0008, q);
        word1(SEL_IE, S_CSR, 32'h0, q);
        checks++; if (q !== 32'h888) begin errors++; $display("FAIL w1_mie got %h exp 00000888", q); end
        word1(SEL_ST, S_CSR, 32'h0, q);
        checks++; if (q !== 32'h8) begin errors++; $display("FAIL w1_mstatus got %h exp 00000008", q); end
    endtask

    task automatic test_rw_w4();
        logic [31:0] q, cin;
        word4(SEL_IE, S_EXT, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, q, cin);
        checks++; if (cin !== 32'hFFFF_FFFF) begin errors++; $display("FAIL w4_ext_csr_in got %h exp ffffffff", cin); end
        wr4(SEL_ST, S_EXT, 32'h0000_0008);
        wr4(SEL_CA, S_EXT, 32'hFFFF_FFFF);
        rd4(SEL_IE, q);
        checks++; if (q !== 32'h888) begin errors++; $display("FAIL w4_mie got %h exp 00000888", q); end
        rd4(SEL_ST, q);
        checks++; if (q !== 32'h8) begin errors++; $display("FAIL w4_mstatus got %h exp 00000008", q); end
        rd4(SEL_CA, q);
        checks++; if (q !== 32'h8000_000F) begin errors++; $display("FAIL w4_mcause got %h exp 8000000f", q); end
        word4(SEL_IE, S_CSR, 1'b0, 32'h0, 32'h00F0_0000, 1'b0, q, cin);
        checks++; if (q !== 32'h00F0_0888) begin errors++; $display("FAIL w4_rf_or got %h exp 00f00888", q); end
    endtask

    task automatic test_csr_ops();
        logic [31:0] q, cin;
        word4(SEL_NONE, S_SET, 1'b0, 32'h0000_00FF, 32'hF0F0_0000, 1'b0, q, cin);
        checks++; if (cin !== 32'hF0F0_00FF) begin errors++; $display("FAIL op_set got %h exp f0f000ff", cin); end
        checks++; if (q !== 32'hF0F0_0000) begin errors++; $display("FAIL op_q got %h exp f0f00000", q); end
        word4(SEL_NONE, S_CLR, 1'b0, 32'h0F0F_0000, 32'hFFFF_0000, 1'b0, q, cin);
        checks++; if (cin !== 32'hF0F0_0000) begin errors++; $display("FAIL op_clr got %h exp f0f00000", cin); end
        word4(SEL_NONE, S_CSR, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, q, cin);
        checks++; if (cin !== 32'h1234_5678) begin errors++; $display("FAIL op_csr got %h exp 12345678", cin); end
        word4(SEL_NONE, S_EXT, 1'b1, 32'hA5A5_A5A5, 32'h0, 1'b0, q, cin);
        checks++; if (cin !== 32'hA5A5_A5A5) begin errors++; $display("FAIL op_imm_sel got %h exp a5a5a5a5", cin); end
    endtask

    task automatic test_timer_irq();
        logic [31:0] q;
        wr4(SEL_IE, S_EXT, 32'h0000_0080);
        wr4(SEL_ST, S_EXT, 32'h0000_0008);
        mtip = 1'b1;
        tick(2, 1'b0);
        checks++; if (irq_w4 !== 1'b0) begin errors++; $display("FAIL mti_early got %b exp 0", irq_w4); end
        tick(1, 1'b0);
        checks++; if (irq_w4 !== 1'b1) begin errors++; $display("FAIL mti_irq got %b exp 1", irq_w4); end
        wait_cycles(2);
        checks++; if (irq_w4 !== 1'b1) begin errors++; $display("FAIL mti_hold got %b exp 1", irq_w4); end
        trap_cycle(4'hF, 1'b0);
        mtip = 1'b0;
        rd4(SEL_CA, q);
        checks++; if (q !== 32'h8000_0007) begin errors++; $display("FAIL mti_mcause got %h exp 80000007", q); end
        rd4(SEL_ST, q);
        checks++; if (q !== 32'h80) begin errors++; $display("FAIL mti_mstatus got %h exp 00000080", q); end
    endtask

    task automatic test_priority();
        logic [31:0] q;
        wr4(SEL_IE, S_EXT, 32'h0000_0888);
        wr4(SEL_ST, S_EXT, 32'h0000_0008);
        meip = 1'b1; mtip = 1'b1;
        tick(3, 1'b0);
        checks++; if (irq_w4 !== 1'b1) begin errors++; $display("FAIL mei_irq got %b exp 1", irq_w4); end
        trap_cycle(4'h0, 1'b0);
        meip = 1'b0; mtip = 1'b0;
        rd4(SEL_CA, q);
        checks++; if (q !== 32'h8000_000B) begin errors++; $display("FAIL mei_mcause got %h exp 8000000b", q); end
        wait_cycles(3);
        wr4(SEL_ST, S_EXT, 32'h0000_0008);
        msip = 1'b1;
        tick(4, 1'b1);
        checks++; if (irq_w4 !== 1'b0) begin errors++; $display("FAIL init_suppress got %b exp 0", irq_w4); end
        tick(1, 1'b0);
        checks++; if (irq_w4 !== 1'b1) begin errors++; $display("FAIL msi_irq got %b exp 1", irq_w4); end
        trap_cycle(4'h0, 1'b0);
        msip = 1'b0;
        rd4(SEL_CA, q);
        checks++; if (q !== 32'h8000_0003) begin errors++; $display("FAIL msi_mcause got %h exp 80000003", q); end
    endtask

    task automatic test_exception_mret();
        logic [31:0] q, cin;
        wait_cycles(3);
        wr4(SEL_ST, S_EXT, 32'h0000_0008);
        checks++; if (irq_w4 !== 1'b0) begin errors++; $display("FAIL exc_noirq got %b exp 0", irq_w4); end
        trap_cycle(4'h4, 1'b0);
        rd4(SEL_CA, q);
        checks++; if (q !== 32'h4) begin errors++; $display("FAIL exc_mcause got %h exp 00000004", q); end
        rd4(SEL_ST, q);
        checks++; if (q !== 32'h80) begin errors++; $display("FAIL exc_mstatus got %h exp 00000080", q); end
        mret_cycle();
        rd4(SEL_ST, q);
        checks++; if (q !== 32'h88) begin errors++; $display("FAIL mret_mstatus got %h exp 00000088", q); end
        trap_cycle(4'h5, 1'b1);
        rd4(SEL_ST, q);
        checks++; if (q !== 32'h80) begin errors++; $display("FAIL trap_mret_mstatus got %h exp 00000080", q); end
        rd4(SEL_CA, q);
        checks++; if (q !== 32'h5) begin errors++; $display("FAIL trap_mret_mcause got %h exp 00000005", q); end
        exc = 4'h6;
        word4(SEL_CA, S_EXT, 1'b0, 32'h8000_000F, 32'h0, 1'b1, q, cin);
        rd4(SEL_CA, q);
        checks++; if (q !== 32'h6) begin errors++; $display("FAIL trap_over_write got %h exp 00000006", q); end
    endtask

    task automatic test_set_clr();
        logic [31:0] q, cin;
        wr4(SEL_IE, S_EXT, 32'h0);
        wr4(SEL_IE, S_SET, 32'h0000_0080);
        rd4(SEL_IE, q);
        checks++; if (q !== 32'h80) begin errors++; $display("FAIL set_mtie got %h exp 00000080", q); end
        word4(SEL_IE, S_SET, 1'b1, 32'h0000_0008, 32'h0, 1'b0, q, cin);
        rd4(SEL_IE, q);
        checks++; if (q !== 32'h88) begin errors++; $display("FAIL set_imm got %h exp 00000088", q); end
        wr4(SEL_IE, S_CLR, 32'h0000_0080);
        rd4(SEL_IE, q);
        checks++; if (q !== 32'h08) begin errors++; $display("FAIL clr_mtie got %h exp 00000008", q); end
        mtip = 1'b1;
        wait_cycles(3);
        rd4(SEL_IP, q);
        checks++; if (q !== 32'h80) begin errors++; $display("FAIL mip_read got %h exp 00000080", q); end
        wr4(SEL_IP, S_EXT, 32'h0000_0888);
        rd4(SEL_IP, q);
        checks++; if (q !== 32'h80) begin errors++; $display("FAIL mip_ro got %h exp 00000080", q); end
        mtip = 1'b0;
        wait_cycles(3);
    endtask

    task automatic test_reset_mid();
        logic [31:0] q;
        wr4(SEL_IE, S_EXT, 32'h0000_0888);
        wr4(SEL_ST, S_EXT, 32'h0000_0088);
        meip = 1'b1;
        tick(3, 1'b0);
        checks++; if (irq_w4 !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b exp 1", irq_w4); end
        quiet();
        mie_en = 1'b1; src = S_EXT; en = 1'b1; rs1_w4 = 4'hF; cnt = 5'd0;
        @(posedge clk); #1;
        cnt = 5'd4; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        quiet();
        meip = 1'b0;
        checks++; if (irq_w4 !== 1'b0) begin errors++; $display("FAIL rstmid_irq got %b exp 0", irq_w4); end
        rd4(SEL_IE, q);
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL rstmid_mie got %h exp 00000000", q); end
        rd4(SEL_ST, q);
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL rstmid_mstatus got %h exp 00000000", q); end
    endtask

    initial begin
        exc = 4'h0;
        quiet();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_rw_w1();
        test_rw_w4();
        test_csr_ops();
        test_timer_irq();
        test_priority();
        test_exception_mret();
        test_set_clr();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serv_csr_irq.md
Name: serv_csr_irq

Overview:
- Parametrised successor to the SERV bit-serial machine-mode CSR unit.
- Handles mstatus.MIE/MPIE, mie, mip and mcause for three interrupt sources: software, timer and external.
- Interrupt priority is fixed; mcause exception codes are supplied by the decoder.
- Processes W bits per cycle beside the register-file-backed CSRs (mscratch, mtvec, mepc, mtval).

Parameters:
- RESET_STRATEGY, "MINI", "MINI" resets the listed state; "NONE" resets nothing.
- W, 1, bits per cycle; legal values 1 or 4.
- B, W-1, MSB index of data buses (derived, not overridden).
- SYNC_STAGES, 2, flop stages on i_msip/i_mtip/i_meip; legal values 0, 1, 2.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_init  in  1  init phase of two-phase instruction; suppresses IRQ sampling
- i_en  in  1  bit-serial phase active
- i_cnt  in  5  bit index of LSB of current group (multiple of W)
- i_cnt_done  in  1  last group of the word
- i_trap  in  1  trap being taken
- i_mret  in  1  mret executing
- i_mstatus_en / i_mie_en / i_mip_en / i_mcause_en  in  1 each  CSR selected
- i_csr_source  in  2  00 CSR, 01 EXT, 10 SET, 11 CLR
- i_csr_d_sel  in  1  1 selects i_csr_imm, 0 selects i_rs1
- i_exc_code  in  4  synchronous exception code from decoder
- i_msip / i_mtip / i_meip  in  1 each  asynchronous-level interrupt lines
- i_rf_csr_out  in  W  register-file CSR read data
- i_csr_imm / i_rs1  in  W  write operands
- o_csr_in  out  W  data to write back
- o_q  out  W  CSR read data
- o_new_irq  out  1  interrupt to be taken

Behaviour:
- Bit map:
  - mstatus: MIE=3, MPIE=7.
  - mie/mip: MSIx=3, MTIx=7, MEIx=11.
  - mcause: code=3:0, INT=31.
  - All other bits read 0 and writes to them are ignored.
- Operand select: d = i_csr_d_sel ? i_csr_imm : i_rs1.
- o_csr_in by i_csr_source:
  - CSR: csr_out.
  - EXT: d.
  - SET: csr_out | d.
  - CLR: csr_out & ~d.
- csr_out, bit k of the group (bit index i_cnt+k):
  - i_rf_csr_out[k], OR'd with
  - the selected internal register bit at that index, gated by i_en & enable.
- o_q = csr_out.
- CSR writes, when enable & i_en and a group covers the bit index:
  - The bit takes o_csr_in[k].
  - mip is read-only; i_mip_en write is ignored.
- Input synchronisation and pending logic:
  - Interrupt lines pass SYNC_STAGES flops to give mip.
  - pend = mip & mie & {3{MIE}}.
  - Priority: MEI(11) > MSI(3) > MTI(7).
- Each cycle with !i_init & i_cnt_done:
  - pend_any_r <= |pend.
  - o_new_irq <= |pend & !pend_any_r.
  - irq_code <= code of the highest-priority pending source.
- o_new_irq is held between updates.
- Trap, when i_trap & i_cnt_done:
  - MPIE <= MIE.
  - MIE <= 0.
  - mcause <= o_new_irq ? {1, irq_code} : {0, i_exc_code}.
- mret: MIE <= MPIE, MPIE <= 1, on the i_cnt_done cycle.
- Simultaneous events:
  - A trap overrides a same-cycle CSR write to mstatus or mcause.
  - mret and trap are mutually exclusive; if both are asserted, the trap wins.
- Reset, RESET_STRATEGY != "NONE":
  - o_new_irq=0, pend_any_r=0, mie=0, MIE=0, MPIE=0, sync flops=0.
  - mcause and irq_code are not reset.
  - Reset mid-instruction discards any partial write.
- Latency:
  - CSR write is visible on the next read.
  - A line edge reaches mip after SYNC_STAGES cycles.
  - o_new_irq updates at the next qualifying i_cnt_done.

Decomposition:
- Package serv_csr_pkg holds:
  - CSR_SOURCE_* constants.
  - Bit positions MIE_BIT=3, MPIE_BIT=7, MSI=3, MTI=7, MEI=11, MCAUSE_INT=31.
  - Cause codes 3, 7, 11.
- Sub-module serv_irq_sync: synchroniser, pending mask, priority encode, rising-edge detect, producing o_new_irq and irq_code.

Test Plan:
- Write mie=0x888 and mstatus=0x8 via EXT, W=1 and W=4, then read back → mie reads 0x888, mstatus reads 0x8, other bits 0.
- Raise i_mtip with MTIE=1, MIE=1 → o_new_irq=1 after SYNC_STAGES cycles plus the next i_cnt_done; trap → mcause=0x80000007, MIE=0, MPIE=1.
- Assert i_meip and i_mtip in the same cycle → mcause=0x8000000B; i_msip alone → 0x80000003.
- Exception trap with i_exc_code=4 and o_new_irq=0 → mcause=0x00000004; then mret → MIE=1 (restored), MPIE=1.
- SET then CLR on mie bit 7 with i_rs1 walking 1 → bit 7 set, then cleared; write to mip → mip unchanged.
- i_rst during an active write group → mie=0, MIE=0, o_new_irq=0 on the next cycle.
